bk_adder_arbiter: RTL and testbench
===================================

Name: bk_adder_arbiter

Overview:
- Shares one combinational 12-bit BrentKung adder instance between N_REQ requesters.
- Round-robin arbiter with valid/ready request ports; operands and sum are registered around the shared adder.
- Single response channel tagged with requester ID, with backpressure.
- Sits between the operand-producing units and the adder; the adder itself stays a separate instance wired to add_a/add_b/add_sum.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- W, 12, operand width; must match the attached adder.
- IDW, 2, requester ID width; must satisfy 2**IDW >= N_REQ.
- CNTW, 16, width of the completed-operation counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  per-requester operand valid.
- req_a  in  N_REQ*W  operand A; requester i occupies bits [i*W +: W].
- req_b  in  N_REQ*W  operand B; same packing as req_a.
- req_ready  out  N_REQ  one-hot grant/accept; all zero when no grant.
- add_a  out  W  registered operand A to the shared adder.
- add_b  out  W  registered operand B to the shared adder.
- add_sum  in  W+1  adder result; MSB is carry-out; combinational from add_a/add_b.
- resp_valid  out  1  result available.
- resp_id  out  IDW  index of the requester that owns the result.
- resp_sum  out  W+1  registered sum.
- resp_ready  in  1  consumer accepts the result.
- busy  out  1  high in EXEC or RESP.
- done_cnt  out  CNTW  number of completed response handshakes; wraps modulo 2**CNTW.

Behaviour:
- Clock and reset: one clock (clk); rst is synchronous, active-high. All state updates on the rising edge of clk.
- Reset values: state=IDLE, add_a=0, add_b=0, resp_sum=0, resp_id=0, resp_valid=0, req_ready=0, done_cnt=0, rr_ptr=N_REQ-1.
  - With rr_ptr=N_REQ-1, requester 0 has highest priority after reset.
- FSM states IDLE, EXEC, RESP.
  - busy is high in EXEC and RESP.
  - resp_valid is high only in RESP.
- Grant window: cycles in IDLE, and RESP cycles where resp_ready=1.
- Arbitration in the grant window:
  - g = first i with req_valid[i]=1, scanning rr_ptr+1, rr_ptr+2, ... modulo N_REQ.
  - req_ready[g]=1, combinational from req_valid; all other req_ready bits are 0.
  - Requesters must not make req_valid depend on req_ready.
- Handshake: req_valid[g] & req_ready[g]. On that edge:
  - add_a <= req_a[g], add_b <= req_b[g], cur_id <= g, rr_ptr <= g.
  - state <= EXEC.
- rr_ptr changes only on a grant.
- Outside the grant window req_ready=0. A request that drops valid before being granted is simply skipped.
- EXEC lasts exactly one cycle:
  - add_a/add_b are held; the adder settles within the cycle.
  - At the edge: resp_sum <= add_sum, resp_id <= cur_id, state <= RESP.
- RESP:
  - resp_sum and resp_id are held stable while resp_ready=0.
  - On resp_ready=1: done_cnt increments; state goes to EXEC if a grant occurs that cycle, otherwise to IDLE.
- Latency and throughput:
  - Request handshake at edge T gives resp_valid=1 from cycle T+2.
  - Sustained throughput is 1 result per 2 cycles under continuous resp_ready=1.
- Back-to-back transfers: resp_valid drops for exactly the one EXEC cycle between them.
- add_a/add_b keep their last operands in IDLE and RESP; they are only updated on a grant.
- Width rules:
  - The sum is unsigned W+1 bits, taken unmodified from the adder, including carry-out.
  - No carry-in; the block performs no arithmetic itself.
- Reset mid-operation: an in-flight EXEC/RESP result is discarded and no response is emitted. rr_ptr returns to N_REQ-1 and done_cnt to 0.
- No requests pending: remain in IDLE with all req_ready=0.
- Only one outstanding operation exists at any time.

Test Plan:
- Single op, carry-out: req_valid=0001, a0=0xFFF, b0=0x001, resp_ready=1.
  - Required: req_ready=0001 on the handshake cycle; resp_valid at T+2 with resp_sum=0x1000, resp_id=0; done_cnt=1.
- Round-robin fairness: all four requesters valid continuously, with a_i=i, b_i=0x100, resp_ready=1.
  - Required: grant order 0,1,2,3,0,1.
  - Required: resp_sum sequence 0x100, 0x101, 0x102, 0x103, 0x100.
  - Required: resp_valid pattern 1,0,1,0 (period 2).
- Backpressure: complete op 2+3 from requester 2, hold resp_ready=0 for 5 cycles with requester 1 valid.
  - Required: resp_sum=0x005 and resp_id=2 stable throughout; req_ready=0 throughout.
  - Required: requester 1 granted in the same cycle resp_ready rises.
- Pointer rotation: serve requester 3 alone, then raise requesters 0 and 3 together.
  - Required: requester 0 is granted first (rr_ptr=3).
- Reset mid-operation: assert rst during EXEC of 0x7FF+0x7FF.
  - Required: no resp_valid afterwards; all outputs at reset values next cycle; next grant goes to the lowest valid index.
- done_cnt wrap: force CNTW=4, complete 17 operations.
  - Required: done_cnt=1.

Source files
------------

// File: rtl/bk_adder_arbiter.sv
// Round-robin front end that time-shares one external W-bit adder among N_REQ requesters.
// Operands and result are registered around the adder; one tagged response channel with backpressure.
module bk_adder_arbiter #(
  parameter int N_REQ = 4,
  parameter int W     = 12,
  parameter int IDW   = 2,
  parameter int CNTW  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  output logic [N_REQ-1:0]   req_ready,
  output logic [W-1:0]       add_a,
  output logic [W-1:0]       add_b,
  input  logic [W:0]         add_sum,
  output logic               resp_valid,
  output logic [IDW-1:0]     resp_id,
  output logic [W:0]         resp_sum,
  input  logic               resp_ready,
  output logic               busy,
  output logic [CNTW-1:0]    done_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t                   r_state, w_next;
  logic [N_REQ-1:0][W-1:0]  w_a, w_b;
  logic [W-1:0]             w_sel_a, w_sel_b;
  logic [IDW-1:0]           r_rr_ptr, r_cur_id, r_resp_id, w_gnt_id;
  logic [W-1:0]             r_add_a, r_add_b;
  logic [W:0]               r_resp_sum;
  logic [CNTW-1:0]          r_done_cnt;
  logic                     w_found, w_win, w_hs;
  logic [N_REQ-1:0]         w_rdy;

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign w_a[i] = req_a[i*W +: W];
    assign w_b[i] = req_b[i*W +: W];
  end

  // Scan rr_ptr+1, rr_ptr+2, ... (mod N_REQ); first valid requester wins.
  always_comb begin : p_arb
    int               idx;
    logic [N_REQ-1:0] sh;
    w_found  = 1'b0;
    w_gnt_id = '0;
    idx      = 0;
    sh       = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      sh = req_valid >> idx;
      if (!w_found && sh[0]) begin
        w_found  = 1'b1;
        w_gnt_id = IDW'(idx);
      end
    end
  end

  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_rdy[i]) begin
        w_sel_a = w_sel_a | w_a[i];
        w_sel_b = w_sel_b | w_b[i];
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_hs) w_next = S_EXEC;
      S_EXEC:  w_next = S_RESP;
      S_RESP:  if (resp_ready) w_next = w_hs ? S_EXEC : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs; the grant window is gated by rst so nothing is accepted during reset.
  always_comb begin
    busy       = (r_state != S_IDLE);
    resp_valid = (r_state == S_RESP);
    w_win      = !rst && ((r_state == S_IDLE) || ((r_state == S_RESP) && resp_ready));
    w_hs       = w_win && w_found;
    w_rdy      = w_hs ? (N_REQ'(1) << w_gnt_id) : '0;
    req_ready  = w_rdy;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_add_a    <= '0;
      r_add_b    <= '0;
      r_cur_id   <= '0;
      r_rr_ptr   <= IDW'(N_REQ - 1);
      r_resp_sum <= '0;
      r_resp_id  <= '0;
      r_done_cnt <= '0;
    end else begin
      if (w_hs) begin
        r_add_a  <= w_sel_a;
        r_add_b  <= w_sel_b;
        r_cur_id <= w_gnt_id;
        r_rr_ptr <= w_gnt_id;
      end
      if (r_state == S_EXEC) begin
        r_resp_sum <= add_sum;
        r_resp_id  <= r_cur_id;
      end
      if ((r_state == S_RESP) && resp_ready)
        r_done_cnt <= r_done_cnt + CNTW'(1);
    end
  end

  assign add_a    = r_add_a;
  assign add_b    = r_add_b;
  assign resp_sum = r_resp_sum;
  assign resp_id  = r_resp_id;
  assign done_cnt = r_done_cnt;

endmodule

// File: tb/tb_bk_adder_arbiter.sv
// Directed bench for bk_adder_arbiter: table-driven round-robin run plus hand-written corner sequences.
// A second instance with a 4-bit counter shares the stimulus to exercise done_cnt wrap.
module tb_bk_adder_arbiter;
  localparam int N = 4, W = 12, IDW = 2;

  logic           clk = 1'b0, rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_a = '0, req_b = '0;
  logic           resp_ready = 1'b0;

  logic [N-1:0]   req_ready, req_ready4;
  logic [W-1:0]   add_a, add_b, add_a4, add_b4;
  logic [W:0]     add_sum, add_sum4, resp_sum, resp_sum4;
  logic           resp_valid, resp_valid4, busy, busy4;
  logic [IDW-1:0] resp_id, resp_id4;
  logic [15:0]    done_cnt;
  logic [3:0]     done_cnt4;

  int n_pass = 0, n_tot = 0;

  always #5 clk = ~clk;

  // Reference adders standing in for the external Brent-Kung instance
  assign add_sum  = {1'b0, add_a}  + {1'b0, add_b};
  assign add_sum4 = {1'b0, add_a4} + {1'b0, add_b4};

  bk_adder_arbiter #(.N_REQ(N), .W(W), .IDW(IDW), .CNTW(16)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_sum(resp_sum),
    .resp_ready(resp_ready), .busy(busy), .done_cnt(done_cnt));

  bk_adder_arbiter #(.N_REQ(N), .W(W), .IDW(IDW), .CNTW(4)) u_dut4 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready4), .add_a(add_a4), .add_b(add_b4), .add_sum(add_sum4),
    .resp_valid(resp_valid4), .resp_id(resp_id4), .resp_sum(resp_sum4),
    .resp_ready(resp_ready), .busy(busy4), .done_cnt(done_cnt4));

  typedef struct {
    logic [3:0]  v;
    logic        rr;
    logic [3:0]  e_rdy;
    logic        e_rv;
    logic        e_busy;
    logic [12:0] e_sum;
    logic [1:0]  e_id;
    logic [15:0] e_done;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; resp_ready = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  // Idle the requesters and wait, bounded, for the block to return to IDLE.
  task automatic drain();
    int k;
    req_valid = '0; resp_ready = 1'b1;
    for (k = 0; k < 20; k++) begin
      mid();
      if (!busy) break;
      step();
    end
    chk("drain_timeout", 32'(k < 20), 32'd1);
    step();
  endtask

  initial begin
    // fairness table: all four valid, a_i=i, b_i=0x100, resp_ready held high
    tbl[0]  = '{4'hF, 1'b1, 4'b0001, 1'b0, 1'b0, 13'h000, 2'd0, 16'd0};
    tbl[1]  = '{4'hF, 1'b1, 4'b0000, 1'b0, 1'b1, 13'h000, 2'd0, 16'd0};
    tbl[2]  = '{4'hF, 1'b1, 4'b0010, 1'b1, 1'b1, 13'h100, 2'd0, 16'd0};
    tbl[3]  = '{4'hF, 1'b1, 4'b0000, 1'b0, 1'b1, 13'h000, 2'd0, 16'd1};
    tbl[4]  = '{4'hF, 1'b1, 4'b0100, 1'b1, 1'b1, 13'h101, 2'd1, 16'd1};
    tbl[5]  = '{4'hF, 1'b1, 4'b0000, 1'b0, 1'b1, 13'h000, 2'd0, 16'd2};
    tbl[6]  = '{4'hF, 1'b1, 4'b1000, 1'b1, 1'b1, 13'h102, 2'd2, 16'd2};
    tbl[7]  = '{4'hF, 1'b1, 4'b0000, 1'b0, 1'b1, 13'h000, 2'd0, 16'd3};
    tbl[8]  = '{4'hF, 1'b1, 4'b0001, 1'b1, 1'b1, 13'h103, 2'd3, 16'd3};
    tbl[9]  = '{4'hF, 1'b1, 4'b0000, 1'b0, 1'b1, 13'h000, 2'd0, 16'd4};
    tbl[10] = '{4'hF, 1'b1, 4'b0010, 1'b1, 1'b1, 13'h100, 2'd0, 16'd4};

    // reset state
    do_reset();
    mid();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_add_a", add_a, 0);
    chk("rst_add_b", add_b, 0);
    chk("rst_resp_sum", resp_sum, 0);
    chk("rst_resp_id", resp_id, 0);
    chk("rst_done_cnt", done_cnt, 0);
    step();

    // single op with carry-out
    set_op(0, 12'hFFF, 12'h001);
    req_valid = 4'b0001; resp_ready = 1'b1;
    mid(); chk("single_req_ready", req_ready, 4'b0001);
    step();
    req_valid = '0;
    mid(); chk("single_exec_rv", resp_valid, 0); chk("single_exec_busy", busy, 1);
    chk("single_add_a", add_a, 12'hFFF); chk("single_add_b", add_b, 12'h001);
    step();
    mid(); chk("single_rv", resp_valid, 1); chk("single_sum", resp_sum, 13'h1000);
    chk("single_id", resp_id, 0);
    step();
    mid(); chk("single_done", done_cnt, 1); chk("single_idle_rv", resp_valid, 0);
    step();

    // round-robin fairness
    do_reset();
    for (int i = 0; i < N; i++) set_op(i, W'(i), 12'h100);
    for (int r = 0; r < 11; r++) begin
      req_valid = tbl[r].v; resp_ready = tbl[r].rr;
      mid();
      chk($sformatf("rr%0d_req_ready", r), req_ready, tbl[r].e_rdy);
      chk($sformatf("rr%0d_resp_valid", r), resp_valid, tbl[r].e_rv);
      chk($sformatf("rr%0d_busy", r), busy, tbl[r].e_busy);
      chk($sformatf("rr%0d_done", r), done_cnt, tbl[r].e_done);
      if (tbl[r].e_rv) begin
        chk($sformatf("rr%0d_sum", r), resp_sum, tbl[r].e_sum);
        chk($sformatf("rr%0d_id", r), resp_id, tbl[r].e_id);
      end
      step();
    end
    drain();

    // backpressure: requester 2 computes 2+3, consumer stalls, requester 1 waits
    set_op(2, 12'h002, 12'h003);
    set_op(1, 12'h010, 12'h020);
    req_valid = 4'b0100; resp_ready = 1'b0;
    mid(); chk("bp_grant2", req_ready, 4'b0100);
    step();
    req_valid = 4'b0010;
    mid(); chk("bp_exec_ready", req_ready, 0);
    step();
    for (int c = 0; c < 5; c++) begin
      mid();
      chk($sformatf("bp%0d_rv", c), resp_valid, 1);
      chk($sformatf("bp%0d_sum", c), resp_sum, 13'h005);
      chk($sformatf("bp%0d_id", c), resp_id, 2);
      chk($sformatf("bp%0d_ready", c), req_ready, 0);
      step();
    end
    resp_ready = 1'b1;
    mid(); chk("bp_release_grant1", req_ready, 4'b0010); chk("bp_release_sum", resp_sum, 13'h005);
    step();
    req_valid = '0;
    mid(); chk("bp_b2b_gap_rv", resp_valid, 0);
    step();
    mid(); chk("bp_next_rv", resp_valid, 1); chk("bp_next_sum", resp_sum, 13'h030);
    chk("bp_next_id", resp_id, 1);
    step();
    drain();

    // pointer rotation: serve 3 alone, then 0 and 3 together -> 0 wins
    set_op(3, 12'h0AA, 12'h001);
    req_valid = 4'b1000;
    mid(); chk("rot_grant3", req_ready, 4'b1000);
    step();
    drain();
    req_valid = 4'b1001;
    mid(); chk("rot_grant0", req_ready, 4'b0001);
    step();
    drain();

    // reset during EXEC
    set_op(0, 12'h7FF, 12'h7FF);
    req_valid = 4'b0001;
    mid(); chk("mid_grant0", req_ready, 4'b0001);
    step();
    req_valid = '0; rst = 1'b1;
    mid(); chk("mid_exec_busy", busy, 1);
    step();
    rst = 1'b0;
    mid();
    chk("mid_rst_rv", resp_valid, 0); chk("mid_rst_busy", busy, 0);
    chk("mid_rst_add_a", add_a, 0); chk("mid_rst_add_b", add_b, 0);
    chk("mid_rst_sum", resp_sum, 0); chk("mid_rst_id", resp_id, 0);
    chk("mid_rst_done", done_cnt, 0); chk("mid_rst_ready", req_ready, 0);
    step();
    for (int c = 0; c < 3; c++) begin
      mid(); chk($sformatf("mid_quiet%0d_rv", c), resp_valid, 0);
      step();
    end
    req_valid = 4'b1010;
    mid(); chk("mid_next_grant", req_ready, 4'b0010);
    step();
    drain();

    // counter wrap: 17 ops, 4-bit instance reads 1
    do_reset();
    for (int n = 0; n < 17; n++) begin
      set_op(0, W'(n), 12'h001);
      req_valid = 4'b0001; resp_ready = 1'b1;
      step();
      drain();
    end
    mid();
    chk("wrap_done4", done_cnt4, 4'd1);
    chk("wrap_done16", done_cnt, 16'd17);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
